// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves data_io upload reads from a 16-bit SDRAM port.
// Build option: define UPLOAD_PREFETCH_EN to fetch the next word speculatively.
module ioctl_upload_reader #(
    parameter logic [7:0]  INDEX     = 8'hFF,
    parameter logic [22:0] BASE_WORD = 23'h0,
    parameter logic [24:0] LEN       = 25'h1000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_upl,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        din_valid,
    output logic        busy,
    output logic        overrun,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [22:0] mem_a,
    input  logic [15:0] mem_q
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SERVE, S_PREF} state_t;

    function automatic logic [22:0] word_of(input logic [23:0] wa);
        logic [23:0] s;
        s = {1'b0, BASE_WORD} + wa;
        return s[22:0];
    endfunction

    function automatic logic [7:0] lane(input logic [15:0] q, input logic hi);
        return hi ? q[15:8] : q[7:0];
    endfunction

    state_t      r_state;
    logic        r_ack_s1;
    logic        r_ack_s;
    logic        r_upl_d;
    logic [15:0] r_cache;
    logic [22:0] r_tag;
    logic        r_cvalid;
    logic        r_pend_v;
    logic [24:0] r_pend_a;
    logic [24:0] r_cur_a;
    logic        r_abort;
    logic [7:0]  r_din;
    logic        r_dvalid;
    logic        r_busy;
    logic        r_overrun;
    logic        r_req;
    logic [22:0] r_mem_a;

    logic        w_active;
    logic        w_rd;
    logic        w_done;
    logic        w_rise;
    logic        w_fall;
    logic        w_req_v;
    logic [24:0] w_req_a;
    logic [22:0] w_req_word;
    logic        w_req_oor;
    logic        w_req_hit;
    logic        w_pf_hit;

    assign w_active   = ioctl_upl && (ioctl_index == INDEX);
    assign w_rd       = ioctl_rd && w_active;
    assign w_done     = (r_ack_s == r_req);
    assign w_rise     = ioctl_upl && !r_upl_d;
    assign w_fall     = !ioctl_upl && r_upl_d;
    // the pending slot always goes ahead of a fresh strobe
    assign w_req_v    = (r_pend_v && ioctl_upl) || w_rd;
    assign w_req_a    = r_pend_v ? r_pend_a : ioctl_addr;
    assign w_req_word = word_of(w_req_a[24:1]);
    assign w_req_oor  = (w_req_a >= LEN);
    assign w_req_hit  = r_cvalid && !w_rise && (r_tag == w_req_word);
    assign w_pf_hit   = r_pend_v && (r_pend_a < LEN) &&
                        (word_of(r_pend_a[24:1]) == r_mem_a);

`ifdef UPLOAD_PREFETCH_EN
    logic w_nxt_req;
    logic w_nxt_cur;
    assign w_nxt_req = ({1'b0, w_req_a} + 26'd1) < {1'b0, LEN};
    assign w_nxt_cur = ({1'b0, r_cur_a} + 26'd1) < {1'b0, LEN};
`endif

    assign ioctl_din = r_din;
    assign din_valid = r_dvalid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign mem_req   = r_req;
    assign mem_a     = r_mem_a;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ack_s1  <= 1'b0;
            r_ack_s   <= 1'b0;
            r_upl_d   <= 1'b0;
            r_cache   <= 16'h0000;
            r_tag     <= 23'h0;
            r_cvalid  <= 1'b0;
            r_pend_v  <= 1'b0;
            r_pend_a  <= 25'h0;
            r_cur_a   <= 25'h0;
            r_abort   <= 1'b0;
            r_din     <= 8'h00;
            r_dvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_req     <= 1'b0;
            r_mem_a   <= 23'h0;
        end else begin
            r_ack_s1 <= mem_ack;
            r_ack_s  <= r_ack_s1;
            r_upl_d  <= ioctl_upl;
            r_dvalid <= 1'b0;
            unique case (r_state)
                S_IDLE: if (w_req_v) begin
                    if (r_pend_v && w_rd) r_pend_a <= ioctl_addr;
                    else if (r_pend_v)    r_pend_v <= 1'b0;
                    r_cur_a <= w_req_a;
                    if (w_req_oor) begin
                        r_din    <= 8'hFF;
                        r_dvalid <= 1'b1;
                    end else if (w_req_hit) begin
                        r_din    <= lane(r_cache, w_req_a[0]);
                        r_dvalid <= 1'b1;
`ifdef UPLOAD_PREFETCH_EN
                        if (w_req_a[0] && w_nxt_req && !(r_pend_v && w_rd)) begin
                            r_mem_a <= w_req_word + 23'd1;
                            r_req   <= ~r_req;
                            r_busy  <= 1'b1;
                            r_state <= S_PREF;
                        end
`endif
                    end else begin
                        r_mem_a <= w_req_word;
                        r_req   <= ~r_req;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: if (w_done) begin
                    if (r_abort) begin
                        r_abort <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cache  <= mem_q;
                        r_tag    <= word_of(r_cur_a[24:1]);
                        r_cvalid <= 1'b1;
                        r_state  <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    r_din    <= lane(r_cache, r_cur_a[0]);
                    r_dvalid <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
`ifdef UPLOAD_PREFETCH_EN
                    if (r_cur_a[0] && w_nxt_cur && ioctl_upl &&
                        !r_pend_v && !w_rd) begin
                        r_mem_a <= r_tag + 23'd1;
                        r_req   <= ~r_req;
                        r_busy  <= 1'b1;
                        r_state <= S_PREF;
                    end
`endif
                end
                S_PREF: if (w_done) begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_abort) begin
                        r_abort <= 1'b0;
                    end else begin
                        r_cache  <= mem_q;
                        r_tag    <= r_mem_a;
                        r_cvalid <= 1'b1;
                        if (w_pf_hit) begin
                            r_din    <= lane(mem_q, r_pend_a[0]);
                            r_dvalid <= 1'b1;
                            r_pend_v <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_rd && r_state != S_IDLE) begin
                if (!r_pend_v) begin
                    r_pend_v <= 1'b1;
                    r_pend_a <= ioctl_addr;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            if (w_rise) begin
                r_cvalid  <= 1'b0;
                r_overrun <= 1'b0;
            end
            // toggle parity must survive an abort, so in-flight acks are still awaited
            if (w_fall) begin
                r_pend_v <= 1'b0;
                r_cvalid <= 1'b0;
                if (r_state == S_SERVE || (r_state != S_IDLE && w_done)) begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_dvalid <= 1'b0;
                    r_abort  <= 1'b0;
                end else if (r_state != S_IDLE) begin
                    r_abort <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb_ioctl_upload_reader: scoreboard bench for ioctl_upload_reader.
// Honours UPLOAD_PREFETCH_EN when the design is built with it.
module tb_ioctl_upload_reader;
    localparam logic [7:0]  IDX  = 8'hFF;
    localparam logic [22:0] BASE = 23'h000100;
    localparam logic [24:0] LEN  = 25'h1000;
    // four cycles in the block plus one cycle in the responder
    localparam int MISS_LAT = 5;
`ifdef UPLOAD_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_upl;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        din_valid;
    logic        busy;
    logic        overrun;
    logic        mem_req;
    logic        mem_ack;
    logic [22:0] mem_a;
    logic [15:0] mem_q;

    typedef struct {
        logic [7:0] b;
        int         lat;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_tog = 0;
    int   resp_dly = 0;
    int   ack_cyc = 0;
    int   t0;
    int   n;
    int   d;
    logic prev_req = 1'b0;

    ioctl_upload_reader #(
        .INDEX     (IDX),
        .BASE_WORD (BASE),
        .LEN       (LEN)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upl   (ioctl_upl),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_rd    (ioctl_rd),
        .ioctl_din   (ioctl_din),
        .din_valid   (din_valid),
        .busy        (busy),
        .overrun     (overrun),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_a       (mem_a),
        .mem_q       (mem_q)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [15:0] memword(input logic [22:0] w);
        if (w == BASE) return 16'hBEEF;
        return {w[7:0] ^ 8'h5A, w[7:0] + 8'h21};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [24:0] a);
        logic [23:0] s;
        logic [15:0] q;
        if (a >= LEN) return 8'hFF;
        s = {1'b0, BASE} + a[24:1];
        q = memword(s[22:0]);
        return a[0] ? q[15:8] : q[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [24:0] a, input bit keep, input int lat);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        if (keep) sb.push_back('{b: exp_byte(a), lat: lat, cyc: cyc});
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        repeat (2) @(negedge clk_sys);
        while ((sb.size() != 0 || busy !== 1'b0) && k < 300) begin
            @(negedge clk_sys);
            k++;
        end
        check({tag, "_drain"}, k < 300, 1);
        repeat (2) @(negedge clk_sys);
    endtask

    // SDRAM responder on the far side of the toggle handshake
    initial begin
        mem_ack = 1'b0;
        mem_q   = 16'h0000;
        wait (reset_n === 1'b0);
        wait (reset_n === 1'b1);
        forever begin
            @(negedge clk_sys);
            if (mem_req !== mem_ack) begin
                repeat (resp_dly) @(negedge clk_sys);
                mem_q   = memword(mem_a);
                mem_ack = mem_req;
                ack_cyc = cyc;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (reset_n === 1'b1 && mem_req !== prev_req) n_tog <= n_tog + 1;
        prev_req <= mem_req;
        if (din_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", din_valid, 0);
            end else begin
                m_e = sb.pop_front();
                check("din", ioctl_din, m_e.b);
                if (m_e.lat >= 0) check("latency", cyc - m_e.cyc, m_e.lat);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b1;
        ioctl_upl   = 1'b0;
        ioctl_index = IDX;
        ioctl_addr  = 25'h0;
        ioctl_rd    = 1'b0;
        #2 reset_n  = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_din", ioctl_din, 8'h00);
        check("rst_valid", din_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_req", mem_req, 0);
        check("rst_mem_a", mem_a, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        ioctl_upl = 1'b1;
        repeat (2) @(negedge clk_sys);

        // sequential pair from one word
        resp_dly = 0;
        t0 = n_tog;
        strobe(25'h0, 1, MISS_LAT);
        drain("seq0");
        check("seq0_tog", n_tog - t0, 1);
        check("seq0_mem_a", mem_a, BASE);
        strobe(25'h1, 1, 1);
        drain("seq1");
        check("seq1_tog", n_tog - t0, 1 + PF);

        // range boundary
        t0 = n_tog;
        strobe(LEN, 1, 1);
        drain("oor");
        check("oor_tog", n_tog - t0, 0);
        strobe(LEN - 25'd1, 1, MISS_LAT);
        drain("last");
        check("last_tog", n_tog - t0, 1);

        // queueing behind a slow miss
        resp_dly = 20;
        strobe(25'h10, 1, -1);
        strobe(25'h11, 1, -1);
        strobe(25'h20, 0, -1);
        strobe(25'h30, 0, -1);
        drain("queue");
        check("overrun_set", overrun, 1);
        ioctl_upl = 1'b0;
        repeat (2) @(negedge clk_sys);
        ioctl_upl = 1'b1;
        @(negedge clk_sys);
        check("overrun_clr", overrun, 0);

        // upload aborted mid-access
        resp_dly = 10;
        t0 = n_tog;
        strobe(25'h40, 0, -1);
        repeat (3) @(negedge clk_sys);
        check("abort_busy", busy, 1);
        ioctl_upl = 1'b0;
        n = 0;
        while (mem_ack !== mem_req && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        d = cyc - ack_cyc;
        check($sformatf("abort_busy_drop_d%0d", d), (d >= 2 && d <= 3), 1);
        check("abort_parity", mem_req, mem_ack);
        repeat (3) @(negedge clk_sys);
        ioctl_upl = 1'b1;
        repeat (2) @(negedge clk_sys);
        strobe(25'h40, 1, -1);
        drain("after_abort");
        check("abort_tog", n_tog - t0, 2);

        // other image index is ignored
        resp_dly = 0;
        t0 = n_tog;
        ioctl_index = 8'h00;
        strobe(25'h50, 0, -1);
        repeat (10) @(negedge clk_sys);
        check("idx_tog", n_tog - t0, 0);
        check("idx_busy", busy, 0);
        ioctl_index = IDX;

        // sequential stream
        t0 = n_tog;
        for (int i = 0; i < 8; i++) begin
            strobe(25'h60 + 25'(i), 1,
                   (i % 2 == 1) ? 1 : ((i == 0 || PF == 0) ? MISS_LAT : 1));
            drain($sformatf("stream%0d", i));
        end
        check("stream_tog", n_tog - t0, 4 + PF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
